serial_cla_subtractor: RTL and testbench

SERIAL_CLA_SUBTRACTOR -- requirements
Module: serial_cla_subtractor

---
 rtl/serial_cla_subtractor.sv | 169 ++++++++++++++++
 tb/tb_serial_cla_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_cla_subtractor.sv
// Multi-cycle subtractor: a - b - borrow_in computed as a + ~b + ~borrow_in,
// CHUNK bits per cycle through a carry-lookahead slice, least significant chunk first.
// Optional feature macro: SUB_OVERFLOW_EN enables the signed overflow flag; when
// undefined the overflow port is tied low and no overflow logic is built.
module serial_cla_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    // Subtrahend is stored already inverted so the datapath is a plain adder.
    logic [WIDTH-1:0]  nb_q, nb_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;

    // Lookahead slice signals for the chunk currently selected by idx_q.
    logic [CHUNK-1:0]  x_chunk;
    logic [CHUNK-1:0]  y_chunk;
    logic [CHUNK-1:0]  p;
    logic [CHUNK-1:0]  g;
    logic [CHUNK:0]    c;
    logic [CHUNK-1:0]  sum;

`ifdef SUB_OVERFLOW_EN
    logic              overflow_q, overflow_d;
`endif

    // Chunk select and carry-lookahead adder slice.
    always_comb begin
        x_chunk = a_q[idx_q * CHUNK +: CHUNK];
        y_chunk = nb_q[idx_q * CHUNK +: CHUNK];
        p       = x_chunk ^ y_chunk;
        g       = x_chunk & y_chunk;
        c       = '0;
        c[0]    = carry_q;
        // Each carry is a flat sum of products of generates, propagates and c[0],
        // so no carry depends on a lower carry inside the slice.
        for (int i = 0; i < int'(CHUNK); i++) begin
            logic prop;
            logic term;
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = term | (prop & carry_q);
        end
        sum = p ^ c[CHUNK-1:0];
    end

    // Next-state logic for the handshake FSM and the operand/result registers.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        overflow_d = overflow_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~borrow_in;
                    idx_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                diff_d[idx_q * CHUNK +: CHUNK] = sum;
                carry_d = c[CHUNK];
                if (idx_q == LastIdx) begin
                    idx_d    = '0;
                    borrow_d = ~c[CHUNK];
`ifdef SUB_OVERFLOW_EN
                    // Operand signs differ (a_msb == ~b_msb) and result sign differs from a.
                    overflow_d = (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                                 (sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    state_d  = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            nb_q     <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Overflow flag register, only present when the feature is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Directed, table-driven bench for serial_cla_subtractor (WIDTH=8, CHUNK=4).
module tb_serial_cla_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    int passed;
    int total;

`ifdef SUB_OVERFLOW_EN
    localparam logic OvEn = 1'b1;
`else
    localparam logic OvEn = 1'b0;
`endif

    serial_cla_subtractor #(
        .WIDTH(8),
        .CHUNK(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one operand set from IDLE, then count clock edges until out_valid.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                          output logic [7:0] rd, output logic rbo, output logic rov,
                          output int lat);
        @(negedge clk);
        a         = va;
        b         = vb;
        borrow_in = vbin;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd  = diff;
        rbo = borrow_out;
        rov = overflow;
    endtask

    logic [7:0] rd;
    logic       rbo;
    logic       rov;
    int         lat;
    int         seen_valid;

    initial begin
        passed = 0;
        total  = 0;
        vecs[0]  = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[1]  = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4]  = '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[9]  = '{8'h3C, 8'h1E, 1'b1, 8'h1D, 1'b0, 1'b0};
        vecs[10] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[11] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        borrow_in = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset diff", diff, 0);
        check("reset borrow_out", borrow_out, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rbo, rov, lat);
            check($sformatf("vec%0d latency", i), lat, 2);
            check($sformatf("vec%0d diff", i), rd, vecs[i].d);
            check($sformatf("vec%0d borrow_out", i), rbo, vecs[i].bo);
            check($sformatf("vec%0d overflow", i), rov, vecs[i].ov & OvEn);
        end

        // Back-pressure in DONE while new operands are offered.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(8'h50, 8'h30, 1'b0, rd, rbo, rov, lat);
        check("hold latency", lat, 2);
        a         = 8'h33;
        b         = 8'h11;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d diff", k), diff, 8'h20);
            check($sformatf("hold%0d in_ready", k), in_ready, 0);
            check($sformatf("hold%0d out_valid", k), out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bubble in_ready", in_ready, 1);
        check("bubble out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("second accept in_ready", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("second op latency", lat, 2);
        check("second op diff", diff, 8'h22);
        check("second op borrow_out", borrow_out, 0);

        // Reset pulse in the middle of CALC.
        @(negedge clk);
        a         = 8'hAA;
        b         = 8'h11;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort diff", diff, 0);
        check("abort borrow_out", borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("abort no out_valid", seen_valid, 0);
        run_op(8'h50, 8'h30, 1'b0, rd, rbo, rov, lat);
        check("post-abort latency", lat, 2);
        check("post-abort diff", rd, 8'h20);
        check("post-abort borrow_out", rbo, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
